// File: rtl/gradient_pkg.sv
// Shared types and constants for the Sobel gradient engine scheduler.
package gradient_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PH1  = 2'd1,
    PH2  = 2'd2,
    RESP = 2'd3
  } state_type;

  localparam int NUM_REQ = 2;
  localparam int REQ_GX  = 0;
  localparam int REQ_GY  = 1;
  localparam int STAT_W  = 16;

endpackage

// File: rtl/gradient_scheduler_if.sv
// Requester, response and engine signals of the gradient scheduler.
interface gradient_scheduler_if
  import gradient_pkg::*;
#(
  parameter int BITS = 8
);

  logic [NUM_REQ-1:0]                 req_valid;
  logic [NUM_REQ-1:0]                 req_ready;
  logic [NUM_REQ-1:0][2:0][BITS-1:0]  req_pixels;
  logic                               resp_valid;
  logic                               resp_ready;
  logic                               resp_id;
  logic [BITS-1:0]                    resp_pixel;
  logic                               eng_en;
  logic [2:0][BITS-1:0]               eng_pixels;
  logic [BITS-1:0]                    eng_out;
  logic                               eng_final;
  logic                               err;
  logic [NUM_REQ-1:0][STAT_W-1:0]     grant_cnt;

  modport slave (
    input  req_valid, req_pixels, resp_ready,
    input  eng_out, eng_final,
    output req_ready, resp_valid, resp_id,
    output resp_pixel, eng_en, eng_pixels,
    output err, grant_cnt
  );

  modport master (
    output req_valid, req_pixels, resp_ready,
    output eng_out, eng_final,
    input  req_ready, resp_valid, resp_id,
    input  resp_pixel, eng_en, eng_pixels,
    input  err, grant_cnt
  );

endinterface

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin arbiter; on a tie the requester not granted last wins.
module rr_arbiter_2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    unique case (1'b1)
      (req == 2'b11): grant = last_grant ? 2'b01 : 2'b10;
      (req == 2'b01): grant = 2'b01;
      (req == 2'b10): grant = 2'b10;
      default:        grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/gradient_scheduler.sv
// Round-robin sharing of one two-phase weighted-sum engine between Gx/Gy.
// Optional grant counters: define GRADIENT_SCHED_STATS_EN.
module gradient_scheduler
  import gradient_pkg::*;
#(
  parameter int BITS = 8
) (
  input logic               clk,
  input logic               n_rst,
  gradient_scheduler_if.slave bus
);

  state_type            state;
  state_type            nxt;
  logic                 last_grant;
  logic                 id;
  logic [1:0]           grant;
  logic                 accept;
  logic                 acc_id;
  logic [2:0][BITS-1:0] px_sel;

  rr_arbiter_2 u_arb (
    .req        (bus.req_valid),
    .last_grant (last_grant),
    .grant      (grant)
  );

  assign accept = (state == IDLE) && (|(bus.req_valid & grant));
  assign acc_id = grant[REQ_GY];
  assign px_sel = bus.req_pixels[acc_id];

  assign bus.req_ready  = (state == IDLE) ? grant : 2'b00;
  assign bus.eng_en     = (state == PH1);
  assign bus.resp_valid = (state == RESP);

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: if (accept) nxt = PH1;
      PH1:  nxt = PH2;
      PH2:  nxt = RESP;
      RESP: if (bus.resp_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state          <= IDLE;
      last_grant     <= 1'b1;
      id             <= 1'b0;
      bus.eng_pixels <= '0;
      bus.resp_pixel <= '0;
      bus.resp_id    <= 1'b0;
      bus.err        <= 1'b0;
    end else begin
      state <= nxt;
      if (accept) begin
        bus.eng_pixels <= px_sel;
        id             <= acc_id;
        last_grant     <= acc_id;
      end
      // result is kept even when the engine was not in its final phase
      if (state == PH2) begin
        bus.resp_pixel <= bus.eng_out;
        bus.resp_id    <= id;
        if (!bus.eng_final) bus.err <= 1'b1;
      end
    end
  end

`ifdef GRADIENT_SCHED_STATS_EN
  logic [NUM_REQ-1:0][STAT_W-1:0] cnt;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (accept && grant[i] && (cnt[i] != '1))
          cnt[i] <= cnt[i] + 1'b1;
      end
    end
  end

  assign bus.grant_cnt = cnt;
`else
  assign bus.grant_cnt = '0;
`endif

endmodule

// File: tb/tb_gradient_scheduler.sv
// Directed bench for gradient_scheduler with a two-phase engine model.
module tb_gradient_scheduler;
  import gradient_pkg::*;

  logic clk;
  logic n_rst;
  logic bad_final;
  logic ph2;
  logic [7:0] acc;

  int n_checks;
  int n_errors;
  int gq[$];
  int rq[$];
  int iq[$];

  gradient_scheduler_if #(.BITS(8)) bus ();

  gradient_scheduler #(.BITS(8)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // engine: PHASE1 sums outer taps, PHASE2 adds the doubled centre tap
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      ph2 <= 1'b0;
      acc <= 8'h00;
    end else begin
      ph2 <= bus.eng_en;
      if (bus.eng_en)
        acc <= bus.eng_pixels[0] + bus.eng_pixels[2];
    end
  end

  assign bus.eng_out   = acc + {bus.eng_pixels[1][6:0], 1'b0};
  assign bus.eng_final = ph2 & ~bad_final;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_px(input int r, input logic [7:0] p0,
                        input logic [7:0] p1, input logic [7:0] p2);
    bus.req_pixels[r][0] = p0;
    bus.req_pixels[r][1] = p1;
    bus.req_pixels[r][2] = p2;
  endtask

  task automatic wait_resp(input string tag);
    int k;
    k = 0;
    while (!bus.resp_valid && k < 12) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (!bus.resp_valid) check(tag, 32'(bus.resp_valid), 32'd1);
  endtask

  task automatic do_reset();
    n_rst = 1'b0;
    @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic one_req(input int r, input logic [7:0] p0,
                         input logic [7:0] p1, input logic [7:0] p2,
                         input logic [7:0] exp, input string tag);
    set_px(r, p0, p1, p2);
    bus.req_valid = 2'b01 << r;
    @(negedge clk);
    #1;
    bus.req_valid = 2'b00;
    wait_resp({tag, "_to"});
    check({tag, "_px"}, 32'(bus.resp_pixel), 32'(exp));
    check({tag, "_id"}, 32'(bus.resp_id), 32'(r));
    @(negedge clk);
  endtask

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    bad_final  = 1'b0;
    n_rst      = 1'b0;
    bus.req_valid  = 2'b00;
    bus.req_pixels = '0;
    bus.resp_ready = 1'b1;
    #2;
    check("rst_ready", 32'(bus.req_ready), 32'd0);
    check("rst_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_en", 32'(bus.eng_en), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    check("rst_px", 32'(bus.eng_pixels), 32'd0);
    check("rst_rpx", 32'(bus.resp_pixel), 32'd0);
    @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);

    // single request latency
    set_px(0, 8'd1, 8'd2, 8'd3);
    bus.req_valid = 2'b01;
    #1;
    check("t0_ready", 32'(bus.req_ready), 32'd1);
    check("t0_en", 32'(bus.eng_en), 32'd0);
    @(negedge clk);
    bus.req_valid = 2'b00;
    #1;
    check("t1_en", 32'(bus.eng_en), 32'd1);
    check("t1_px", 32'(bus.eng_pixels), 32'h030201);
    @(negedge clk);
    check("t2_en", 32'(bus.eng_en), 32'd0);
    check("t2_valid", 32'(bus.resp_valid), 32'd0);
    @(negedge clk);
    check("t3_valid", 32'(bus.resp_valid), 32'd1);
    check("t3_px", 32'(bus.resp_pixel), 32'd8);
    check("t3_id", 32'(bus.resp_id), 32'd0);
    @(negedge clk);
    check("t4_valid", 32'(bus.resp_valid), 32'd0);

    // signed wrap
    one_req(1, 8'hFF, 8'd64, 8'd0, 8'd127, "wrap1");
    one_req(0, 8'hFD, 8'hFE, 8'd5, 8'hFE, "wrap2");

    // contention from a fresh reset
    do_reset();
    set_px(0, 8'd1, 8'd2, 8'd3);
    set_px(1, 8'hFD, 8'hFE, 8'd5);
    bus.req_valid = 2'b11;
    for (int c = 0; c < 18; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      check("two_hot", 32'(bus.req_ready == 2'b11), 32'd0);
      if (bus.req_ready == 2'b01) gq.push_back(0);
      if (bus.req_ready == 2'b10) gq.push_back(1);
      if (bus.resp_valid) begin
        rq.push_back(c);
        iq.push_back(int'(bus.resp_id));
      end
    end
    bus.req_valid = 2'b00;
    check("cn_ngrant", 32'(gq.size() >= 4), 32'd1);
    check("cn_nresp", 32'(rq.size() >= 3), 32'd1);
    if (gq.size() >= 4 && rq.size() >= 3) begin
      check("cn_g0", 32'(gq[0]), 32'd0);
      check("cn_g1", 32'(gq[1]), 32'd1);
      check("cn_g2", 32'(gq[2]), 32'd0);
      check("cn_g3", 32'(gq[3]), 32'd1);
      check("cn_r0", 32'(rq[0]), 32'd3);
      check("cn_d1", 32'(rq[1] - rq[0]), 32'd4);
      check("cn_d2", 32'(rq[2] - rq[1]), 32'd4);
      check("cn_i0", 32'(iq[0]), 32'd0);
      check("cn_i1", 32'(iq[1]), 32'd1);
    end
    wait_resp("cn_drain");
    @(negedge clk);
    #1;

    // backpressure
    bus.resp_ready = 1'b0;
    set_px(1, 8'd1, 8'd1, 8'd1);
    bus.req_valid = 2'b10;
    @(negedge clk);
    #1;
    wait_resp("bp_to");
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      #1;
      check("bp_valid", 32'(bus.resp_valid), 32'd1);
      check("bp_px", 32'(bus.resp_pixel), 32'd4);
      check("bp_id", 32'(bus.resp_id), 32'd1);
      check("bp_ready", 32'(bus.req_ready), 32'd0);
    end
    bus.req_valid  = 2'b00;
    bus.resp_ready = 1'b1;
    @(negedge clk);
    #1;
    check("bp_done", 32'(bus.resp_valid), 32'd0);
    @(negedge clk);

    // reset during PH2
    set_px(1, 8'd9, 8'd9, 8'd9);
    bus.req_valid = 2'b10;
    @(negedge clk);
    bus.req_valid = 2'b00;
    @(negedge clk);
    #1;
    check("mr_ph2", 32'(bus.eng_final), 32'd1);
    n_rst = 1'b0;
    #1;
    check("mr_valid", 32'(bus.resp_valid), 32'd0);
    check("mr_en", 32'(bus.eng_en), 32'd0);
    check("mr_px", 32'(bus.eng_pixels), 32'd0);
    check("mr_rpx", 32'(bus.resp_pixel), 32'd0);
    check("mr_cnt", 32'(bus.grant_cnt), 32'd0);
    @(negedge clk);
    n_rst = 1'b1;
    begin
      logic seen;
      seen = 1'b0;
      for (int k = 0; k < 6; k++) begin
        @(negedge clk);
        #1;
        if (bus.resp_valid) seen = 1'b1;
      end
      check("mr_ghost", 32'(seen), 32'd0);
    end

    // first grant after release, then protocol error
    set_px(0, 8'd2, 8'd3, 8'd4);
    bus.req_valid = 2'b11;
    bad_final = 1'b1;
    #1;
    check("mr_first", 32'(bus.req_ready), 32'd1);
    @(negedge clk);
    bus.req_valid = 2'b00;
    wait_resp("pe_to");
    check("pe_err", 32'(bus.err), 32'd1);
    check("pe_px", 32'(bus.resp_pixel), 32'd12);
    @(negedge clk);
    bad_final = 1'b0;
    one_req(1, 8'd1, 8'd0, 8'd1, 8'd2, "pe_good");
    check("pe_sticky", 32'(bus.err), 32'd1);
`ifdef GRADIENT_SCHED_STATS_EN
    check("stat_cnt", 32'(bus.grant_cnt), 32'h0001_0001);
`else
    check("stat_cnt", 32'(bus.grant_cnt), 32'd0);
`endif
    do_reset();
    check("pe_clear", 32'(bus.err), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
